// File: rtl/ace_rd_responder.sv
// ACE read responder backed by a line-indexed memory, with a backdoor write port that
// issues a MakeInvalid snoop for each written line.
module ace_rd_responder #(
    parameter int unsigned ACE_XDATA_WIDTH  = 256,
    parameter int unsigned ACE_AXADDR_WIDTH = 32,
    parameter int unsigned MEM_LINES        = 1024,
    parameter int unsigned RD_LATENCY       = 2,
    parameter int unsigned ACE_ID_WIDTH     = 4,
    parameter int unsigned ACE_USER_WIDTH   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ACE_ID_WIDTH-1:0]     ace_arid,
    input  logic [ACE_AXADDR_WIDTH-1:0] ace_araddr,
    input  logic [7:0]                  ace_arlen,
    input  logic [2:0]                  ace_arsize,
    input  logic [1:0]                  ace_arburst,
    input  logic                        ace_arlock,
    input  logic [3:0]                  ace_arcache,
    input  logic [2:0]                  ace_arprot,
    input  logic [3:0]                  ace_arqos,
    input  logic [3:0]                  ace_arregion,
    input  logic [ACE_USER_WIDTH-1:0]   ace_aruser,
    input  logic [3:0]                  ace_arsnoop,
    input  logic [1:0]                  ace_ardomain,
    input  logic [1:0]                  ace_arbar,
    input  logic                        ace_arvalid,
    output logic                        ace_arready,
    output logic [ACE_ID_WIDTH-1:0]     ace_rid,
    output logic [ACE_XDATA_WIDTH-1:0]  ace_rdata,
    output logic [3:0]                  ace_rresp,
    output logic                        ace_rlast,
    output logic [ACE_USER_WIDTH-1:0]   ace_ruser,
    output logic                        ace_rvalid,
    input  logic                        ace_rready,
    input  logic                        ace_rack,
    output logic                        ace_acvalid,
    output logic [ACE_AXADDR_WIDTH-1:0] ace_acaddr,
    output logic [3:0]                  ace_acsnoop,
    output logic [2:0]                  ace_acprot,
    input  logic                        ace_acready,
    input  logic                        ace_crvalid,
    input  logic [4:0]                  ace_crresp,
    output logic                        ace_crready,
    input  logic                        ace_cdvalid,
    input  logic [ACE_XDATA_WIDTH-1:0]  ace_cddata,
    input  logic                        ace_cdlast,
    output logic                        ace_cdready,
    input  logic                        mem_we,
    input  logic [ACE_AXADDR_WIDTH-1:0] mem_waddr,
    input  logic [ACE_XDATA_WIDTH-1:0]  mem_wdata,
    output logic                        mem_wready
);

    localparam int unsigned IdxW = $clog2(MEM_LINES);
    localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [1:0]  BurstIncr = 2'b01;
    localparam logic [3:0]  SnoopMakeInvalid = 4'b1101;

    typedef enum logic [1:0] {RdIdle, RdWait, RdResp, RdAck} rd_state_e;
    typedef enum logic [1:0] {SnIdle, SnAc, SnCr, SnCd} sn_state_e;

    logic [ACE_XDATA_WIDTH-1:0] mem [MEM_LINES];

    rd_state_e                  rd_state_q, rd_state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [IdxW-1:0]            idx_q, idx_d, idx_inc;
    logic [8:0]                 beats_q, beats_d;
    logic [1:0]                 burst_q, burst_d;
    logic [ACE_ID_WIDTH-1:0]    rid_q, rid_d;
    logic [ACE_XDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]                 rresp_q, rresp_d;
    logic                       rlast_q, rlast_d;
    logic                       arready_q, arready_d;

    sn_state_e                  sn_state_q, sn_state_d;
    logic [ACE_AXADDR_WIDTH-1:0] acaddr_q, acaddr_d;
    logic [3:0]                 acsnoop_q, acsnoop_d;
    logic                       mem_wready_q, mem_wready_d;
    logic                       mem_wr;

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        rd_state_d = rd_state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        beats_d    = beats_q;
        burst_d    = burst_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        unique case (rd_state_q)
            RdIdle: begin
                if (ace_arvalid && arready_q) begin
                    rid_d      = ace_arid;
                    idx_d      = ace_araddr[5 +: IdxW];
                    beats_d    = {1'b0, ace_arlen} + 9'd1;
                    burst_d    = ace_arburst;
                    cnt_d      = CntW'(RD_LATENCY - 1);
                    rd_state_d = RdWait;
                end
            end
            RdWait: begin
                if (cnt_q == '0) begin
                    rd_state_d = RdResp;
                    rdata_d    = mem[idx_q];
                    rlast_d    = (beats_q == 9'd1);
                    rresp_d    = (burst_q == BurstIncr) ? 4'b0000 : 4'b0010;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RdResp: begin
                if (ace_rready) begin
                    idx_d   = idx_inc;
                    beats_d = beats_q - 9'd1;
                    if (rlast_q) begin
                        rd_state_d = RdAck;
                        rlast_d    = 1'b0;
                    end else begin
                        // Memory is sampled at the start of each beat, so earlier writes are seen.
                        rdata_d = mem[idx_inc];
                        rlast_d = (beats_q == 9'd2);
                    end
                end
            end
            RdAck: begin
                if (ace_rack) rd_state_d = RdIdle;
            end
        endcase
        arready_d = (rd_state_d == RdIdle);
    end

    always_comb begin
        sn_state_d = sn_state_q;
        acaddr_d   = acaddr_q;
        acsnoop_d  = acsnoop_q;
        mem_wr     = 1'b0;
        unique case (sn_state_q)
            SnIdle: begin
                if (mem_we && mem_wready_q) begin
                    mem_wr     = 1'b1;
                    acaddr_d   = {mem_waddr[ACE_AXADDR_WIDTH-1:5], 5'b0};
                    acsnoop_d  = SnoopMakeInvalid;
                    sn_state_d = SnAc;
                end
            end
            SnAc: if (ace_acready) sn_state_d = SnCr;
            SnCr: if (ace_crvalid) sn_state_d = ace_crresp[0] ? SnCd : SnIdle;
            SnCd: if (ace_cdvalid && ace_cdlast) sn_state_d = SnIdle;
        endcase
        mem_wready_d = (sn_state_d == SnIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q   <= RdIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            beats_q      <= '0;
            burst_q      <= '0;
            rid_q        <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rlast_q      <= 1'b0;
            arready_q    <= 1'b0;
            sn_state_q   <= SnIdle;
            acaddr_q     <= '0;
            acsnoop_q    <= '0;
            mem_wready_q <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            beats_q      <= beats_d;
            burst_q      <= burst_d;
            rid_q        <= rid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rlast_q      <= rlast_d;
            arready_q    <= arready_d;
            sn_state_q   <= sn_state_d;
            acaddr_q     <= acaddr_d;
            acsnoop_q    <= acsnoop_d;
            mem_wready_q <= mem_wready_d;
        end
    end

    // Contents survive reset; mem_wready_q is low while reset is held so no write slips in.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[mem_waddr[5 +: IdxW]] <= mem_wdata;
    end

    assign ace_arready = arready_q;
    assign ace_rid     = rid_q;
    assign ace_rdata   = rdata_q;
    assign ace_rresp   = rresp_q;
    assign ace_rlast   = rlast_q;
    assign ace_ruser   = '0;
    assign ace_rvalid  = (rd_state_q == RdResp);
    assign ace_acvalid = (sn_state_q == SnAc);
    assign ace_acaddr  = acaddr_q;
    assign ace_acsnoop = acsnoop_q;
    assign ace_acprot  = '0;
    assign ace_crready = (sn_state_q == SnCr);
    assign ace_cdready = (sn_state_q == SnCd);
    assign mem_wready  = mem_wready_q;

    logic unused_inputs;
    assign unused_inputs = ^{ace_arsize, ace_arlock, ace_arcache, ace_arprot, ace_arqos,
                             ace_arregion, ace_aruser, ace_arsnoop, ace_ardomain, ace_arbar,
                             ace_araddr, ace_crresp, ace_cddata, mem_waddr};

endmodule

// File: tb/tb_ace_rd_responder.sv
// Randomised scoreboard bench for ace_rd_responder: expected R beats and AC snoops are queued
// from a line-array model, and monitors pop and compare on each handshake.
module tb_ace_rd_responder;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int ML = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    ace_arid;
    logic [AW-1:0] ace_araddr;
    logic [7:0]    ace_arlen;
    logic [1:0]    ace_arburst;
    logic          ace_arvalid, ace_arready;
    logic [3:0]    ace_rid;
    logic [DW-1:0] ace_rdata;
    logic [3:0]    ace_rresp;
    logic          ace_rlast;
    logic [0:0]    ace_ruser;
    logic          ace_rvalid, ace_rready, ace_rack;
    logic          ace_acvalid, ace_acready;
    logic [AW-1:0] ace_acaddr;
    logic [3:0]    ace_acsnoop;
    logic [2:0]    ace_acprot;
    logic          ace_crvalid, ace_crready;
    logic [4:0]    ace_crresp;
    logic          ace_cdvalid, ace_cdlast, ace_cdready;
    logic [DW-1:0] ace_cddata;
    logic          mem_we, mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    ace_rd_responder #(
        .ACE_XDATA_WIDTH (DW),
        .ACE_AXADDR_WIDTH(AW),
        .MEM_LINES       (ML),
        .RD_LATENCY      (RL),
        .ACE_ID_WIDTH    (4),
        .ACE_USER_WIDTH  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ace_arid    (ace_arid),
        .ace_araddr  (ace_araddr),
        .ace_arlen   (ace_arlen),
        .ace_arsize  (3'd5),
        .ace_arburst (ace_arburst),
        .ace_arlock  (1'b0),
        .ace_arcache (4'd0),
        .ace_arprot  (3'd0),
        .ace_arqos   (4'd0),
        .ace_arregion(4'd0),
        .ace_aruser  (1'b0),
        .ace_arsnoop (4'd0),
        .ace_ardomain(2'd0),
        .ace_arbar   (2'd0),
        .ace_arvalid (ace_arvalid),
        .ace_arready (ace_arready),
        .ace_rid     (ace_rid),
        .ace_rdata   (ace_rdata),
        .ace_rresp   (ace_rresp),
        .ace_rlast   (ace_rlast),
        .ace_ruser   (ace_ruser),
        .ace_rvalid  (ace_rvalid),
        .ace_rready  (ace_rready),
        .ace_rack    (ace_rack),
        .ace_acvalid (ace_acvalid),
        .ace_acaddr  (ace_acaddr),
        .ace_acsnoop (ace_acsnoop),
        .ace_acprot  (ace_acprot),
        .ace_acready (ace_acready),
        .ace_crvalid (ace_crvalid),
        .ace_crresp  (ace_crresp),
        .ace_crready (ace_crready),
        .ace_cdvalid (ace_cdvalid),
        .ace_cddata  (ace_cddata),
        .ace_cdlast  (ace_cdlast),
        .ace_cdready (ace_cdready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wready  (mem_wready)
    );

    typedef struct {
        logic [3:0]    id;
        logic [DW-1:0] data;
        logic [3:0]    resp;
        logic          last;
    } beat_t;

    beat_t         exp_r[$];
    logic [AW-1:0] exp_ac[$];
    logic [DW-1:0] mdl [ML];
    int            n_chk = 0;
    int            n_fail = 0;
    int            rr_mode = 0;
    bit            agent_en = 1'b1;
    bit            cr_dt = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rready pattern: 0 = always ready, 1 = random, otherwise stalled
    initial begin
        ace_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       ace_rready = 1'b1;
                1:       ace_rready = 1'($urandom % 2);
                default: ace_rready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every R and AC handshake against the queued expectations
    initial begin
        bit          held;
        logic [73:0] held_vec;
        beat_t       e;
        logic [AW-1:0] a;
        held = 1'b0;
        held_vec = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else begin
                if (held) chk("r_stable", {ace_rvalid, ace_rid, ace_rdata, ace_rresp, ace_rlast},
                              held_vec);
                if (ace_rvalid && ace_rready) begin
                    if (exp_r.size() == 0) begin
                        chk("r_unexpected", 1, 0);
                    end else begin
                        e = exp_r.pop_front();
                        chk("rid", ace_rid, e.id);
                        chk("rdata", ace_rdata, e.data);
                        chk("rresp", ace_rresp, e.resp);
                        chk("rlast", ace_rlast, e.last);
                        chk("ruser", ace_ruser, 0);
                    end
                end
                held = ace_rvalid && !ace_rready;
                held_vec = {ace_rvalid, ace_rid, ace_rdata, ace_rresp, ace_rlast};
                if (ace_acvalid && ace_acready) begin
                    if (exp_ac.size() == 0) begin
                        chk("ac_unexpected", 1, 0);
                    end else begin
                        a = exp_ac.pop_front();
                        chk("acaddr", ace_acaddr, a);
                        chk("acsnoop", ace_acsnoop, 4'b1101);
                        chk("acprot", ace_acprot, 0);
                    end
                end
            end
        end
    end

    // Snoop master agent: accepts AC, answers CR, sends two CD beats when data transfer is set
    initial begin
        ace_acready = 1'b0;
        ace_crvalid = 1'b0;
        ace_crresp  = '0;
        ace_cdvalid = 1'b0;
        ace_cdlast  = 1'b0;
        ace_cddata  = '0;
        forever begin
            @(negedge clk);
            if (agent_en && rst && ace_acvalid) begin
                bit dt;
                int t;
                dt = cr_dt;
                @(posedge clk); #1 ace_acready = 1'b1;
                @(posedge clk); #1 ace_acready = 1'b0;
                ace_crvalid = 1'b1;
                ace_crresp  = {4'b0, dt};
                t = 0;
                do begin @(negedge clk); t++; end while (!ace_crready && t < 20);
                if (!ace_crready) chk("cr_timeout", 0, 1);
                @(posedge clk); #1 ace_crvalid = 1'b0;
                if (dt) begin
                    for (int b = 0; b < 2; b++) begin
                        ace_cdvalid = 1'b1;
                        ace_cdlast  = (b == 1);
                        ace_cddata  = {$urandom, $urandom};
                        t = 0;
                        do begin @(negedge clk); t++; end while (!ace_cdready && t < 20);
                        if (!ace_cdready) chk("cd_timeout", 0, 1);
                        @(posedge clk); #1;
                    end
                    ace_cdvalid = 1'b0;
                    ace_cdlast  = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit dt);
        int t;
        cr_dt = dt;
        @(posedge clk); #1;
        mem_we = 1'b1; mem_waddr = addr; mem_wdata = data;
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_wready && t < 50);
        if (!mem_wready) begin
            chk("wready_timeout", 0, 1);
            mem_we = 1'b0;
            return;
        end
        exp_ac.push_back({addr[AW-1:5], 5'b0});
        @(posedge clk); #1 mem_we = 1'b0;
        mdl[addr[5 +: 4]] = data;
        @(negedge clk);
        chk("wready_busy", mem_wready, 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_wready && t < 50);
        chk("snoop_done", mem_wready, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst);
        int t;
        logic [3:0] idx;
        beat_t e;
        for (int b = 0; b <= len; b++) begin
            idx    = addr[5 +: 4] + 4'(b);
            e.id   = id;
            e.data = mdl[idx];
            e.resp = (burst == 2'b01) ? 4'b0000 : 4'b0010;
            e.last = (b == len);
            exp_r.push_back(e);
        end
        @(posedge clk); #1;
        ace_arid = id; ace_araddr = addr; ace_arlen = 8'(len); ace_arburst = burst;
        ace_arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ace_arready && t < 50);
        if (!ace_arready) begin
            chk("arready_timeout", 0, 1);
            ace_arvalid = 1'b0;
            exp_r.delete();
            return;
        end
        @(posedge clk); #1 ace_arvalid = 1'b0;
        for (int k = 1; k <= RL + 1; k++) begin
            @(negedge clk);
            chk("rvalid_latency", ace_rvalid, (k == RL + 1));
            chk("arready_busy", ace_arready, 0);
        end
        #1;
        t = 0;
        while (exp_r.size() != 0 && t < 200) begin @(negedge clk); #1; t++; end
        if (exp_r.size() != 0) begin
            chk("r_timeout", exp_r.size(), 0);
            exp_r.delete();
        end
        @(posedge clk); #1;
        repeat ($urandom % 3) begin
            @(negedge clk);
            chk("arready_ack", ace_arready, 0);
        end
        @(posedge clk); #1 ace_rack = 1'b1;
        @(posedge clk); #1 ace_rack = 1'b0;
        @(negedge clk);
        chk("arready_after_rack", ace_arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        ace_arid = '0; ace_araddr = '0; ace_arlen = '0; ace_arburst = '0; ace_arvalid = 1'b0;
        ace_rack = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", ace_arready, 0);
        chk("rst_mem_wready", mem_wready, 0);
        chk("rst_rvalid", ace_rvalid, 0);
        chk("rst_acvalid", ace_acvalid, 0);
        chk("rst_readies", {ace_crready, ace_cdready}, 0);
        chk("rst_rdata", ace_rdata, 0);
        chk("rst_acaddr", ace_acaddr, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Preload every line through aliased addresses
        for (int i = 0; i < ML; i++) begin
            logic [AW-1:0] a;
            a = ($urandom & 32'hFFFF_FE00) | (i << 5) | ($urandom % 32);
            do_write(a, (i == 4) ? {8{8'hA5}} : {$urandom, $urandom}, 1'($urandom % 2));
        end

        rr_mode = 0;
        do_read(4'd3, 32'h80, 0, 2'b01);
        @(posedge clk); #1 ace_rack = 1'b1;
        @(posedge clk); #1 ace_rack = 1'b0;
        do_read(4'd5, 32'h40, 2, 2'b01);
        rr_mode = 1;
        do_read(4'd7, (ML - 1) * 32, 1, 2'b01);
        do_read(4'd2, 32'h100, 1, 2'b00);
        do_write(32'h40, {$urandom, $urandom}, 1'b1);

        for (int n = 0; n < 30; n++) begin
            if ($urandom % 3 == 0)
                do_write($urandom, {$urandom, $urandom}, 1'($urandom % 2));
            else
                do_read(4'($urandom), $urandom, $urandom % 4, 2'($urandom % 3));
        end

        // Reset with a snoop parked in AC and a read stalled in RESP
        agent_en = 1'b0;
        rr_mode = 2;
        @(posedge clk); #1;
        mem_we = 1'b1; mem_waddr = 32'h2A0; mem_wdata = {$urandom, $urandom};
        t = 0;
        do begin @(negedge clk); t++; end while (!mem_wready && t < 50);
        @(posedge clk); #1 mem_we = 1'b0;
        mdl[5] = mem_wdata;
        @(negedge clk);
        chk("acvalid_pending", ace_acvalid, 1);
        @(posedge clk); #1;
        ace_arid = 4'd1; ace_araddr = 32'h60; ace_arlen = 8'd3; ace_arburst = 2'b01;
        ace_arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ace_arready && t < 50);
        @(posedge clk); #1 ace_arvalid = 1'b0;
        repeat (RL + 1) @(negedge clk);
        chk("rvalid_stalled", ace_rvalid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valids", {ace_rvalid, ace_rlast, ace_acvalid}, 0);
        chk("mid_rst_readies", {ace_arready, ace_crready, ace_cdready, mem_wready}, 0);
        chk("mid_rst_rid_rresp", {ace_rid, ace_rresp}, 0);
        chk("mid_rst_rdata", ace_rdata, 0);
        chk("mid_rst_ac", {ace_acaddr, ace_acsnoop}, 0);
        repeat (2) @(negedge clk);
        chk("rst_held_arready", ace_arready, 0);
        #2 rst = 1'b1;
        agent_en = 1'b1;
        rr_mode = 1;
        repeat (2) @(posedge clk);
        do_read(4'd9, 32'h0, ML - 1, 2'b01);
        do_read(4'd4, 32'h80, 0, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ace_rd_responder.md
ACE_RD_RESPONDER -- requirements
Module: ace_rd_responder

Interface
REQ-001 SHALL have parameters: ACE_XDATA_WIDTH, default 256, data beat width; ACE_AXADDR_WIDTH, default 32, address width; MEM_LINES, default 1024, power-of-two line count; RD_LATENCY, default 2, cycles from AR accept to first rvalid (>=1).
REQ-002 SHALL have ports: clk  in  1  sole clock.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ace_ar*  in/out  package widths  ACE AR channel, responder side: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arsnoop, ardomain, arbar, arvalid in; arready out.
REQ-005 ace_r*  out/in  package widths  ACE R channel: rid, rdata, rresp, rlast, ruser, rvalid out; rready in.
REQ-006 ace_rack  in  1  read acknowledge.
REQ-007 ace_ac*  out/in  ACE AC channel: acvalid, acaddr, acsnoop, acprot out; acready in.
REQ-008 ace_cr*  in/out  ACE CR channel: crvalid, crresp in; crready out.
REQ-009 ace_cd*  in/out  ACE CD channel: cdvalid, cddata, cdlast in; cdready out.
REQ-010 mem_we, mem_waddr[ACE_AXADDR_WIDTH], mem_wdata[ACE_XDATA_WIDTH]  in; mem_wready  out  1  backdoor line write.

Function
REQ-011 Line index SHALL be addr[5+log2(MEM_LINES)-1:5]; upper bits ignored (aliasing).
REQ-012 Read FSM states: IDLE, WAIT, RESP, ACK; arready=1 only in IDLE.
REQ-013 AR handshake in IDLE SHALL latch arid, index, beats=arlen+1, arburst; go WAIT with counter=RD_LATENCY-1.
REQ-014 WAIT SHALL decrement counter each cycle; at 0 go RESP next cycle (first rvalid exactly RD_LATENCY cycles after AR handshake edge).
REQ-015 RESP: rvalid=1, rid=latched arid, rdata=memory[index] sampled on entry to each beat and held stable while rready=0.
REQ-016 Each R handshake SHALL advance index by 1 modulo MEM_LINES and decrement beats; rlast=1 only on final beat.
REQ-017 rresp SHALL be 4'b0000 for arburst=INCR, 4'b0010 (SLVERR, data still returned) otherwise; ruser=0.
REQ-018 After final R handshake go ACK; arready held 0 until ace_rack=1 sampled, then IDLE (one outstanding transaction).
REQ-019 ace_rack outside ACK SHALL be ignored.
REQ-020 Snoop FSM states: S_IDLE, S_AC, S_CR, S_CD; mem_wready=1 only in S_IDLE.
REQ-021 mem_we&&mem_wready SHALL write memory at that edge and enter S_AC with acaddr=line-aligned mem_waddr, acsnoop=4'b1101 (MakeInvalid), acprot=0.
REQ-022 S_AC: acvalid=1 until acready; then S_CR with crready=1.
REQ-023 On crvalid: crresp[0]=1 (DataTransfer) -> S_CD, else S_IDLE.
REQ-024 S_CD: cdready=1; cddata discarded; cdlast handshake -> S_IDLE.
REQ-025 Read and snoop FSMs SHALL run independently; backdoor write to a line being returned SHALL be visible only on beats sampled after the write edge.
REQ-026 All channel outputs SHALL be registered or derived solely from state; no combinational path from any input to any output.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE/S_IDLE, counters 0, arready=0 while asserted, rvalid=rlast=acvalid=crready=cdready=mem_wready=0; rid, rdata, rresp, acaddr, acsnoop=0.
REQ-028 Memory contents SHALL NOT be cleared by reset; in-flight transactions are dropped.

Verification
REQ-029 Preload line 4=0xA5..A5; AR araddr=0x80, arlen=0, arid=3, RD_LATENCY=2 -> rvalid 2 cycles after AR edge, rid=3, rdata=0xA5..A5, rlast=1, rresp=0; arready=0 until rack.
REQ-030 AR araddr=(MEM_LINES-1)*32, arlen=1, rready toggling -> beats line MEM_LINES-1 then line 0, data stable during stalls, rlast only on beat 2.
REQ-031 AR arburst=FIXED -> rresp=4'b0010, beat data correct.
REQ-032 mem_we to 0x40 -> acvalid with acaddr=0x40, acsnoop=4'b1101; crresp=5'b00001 -> cdready until cdlast; mem_wready=0 throughout, 1 after.
REQ-033 rst asserted mid-burst and mid-snoop -> all valids/readies 0 immediately; after release AR accepted, memory unchanged.
REQ-034 ace_rack pulsed in IDLE -> ignored; next AR accepted normally.
